// File: rtl/aes_ark_keysched.sv
// AddRoundKey stage for AES-128 that expands the key one round at a time.
// Ports: clk/rst, start/key load a block; state_in handshake in, state_out/out_valid/round_idx/round_key/busy/done out.

module aes_sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry v sits at msb index 2047-8v, which is {~v, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_byte
    assign dout[g*8 +: 8] = sbox(din[g*8 +: 8]);
  end

endmodule

module aes_ark_keysched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] state_in,
  input  logic         state_in_valid,
  output logic         state_in_ready,
  output logic [127:0] state_out,
  output logic         out_valid,
  output logic [3:0]   round_idx,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE,
    RUN
  } st_t;

  localparam logic [3:0] LAST = 4'(NR);

  st_t          st, st_nxt;
  logic [127:0] rk;
  logic [3:0]   rcnt;
  logic         load, xfer, last;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] sb_out;
  logic [3:0]   rnext;
  logic         unused_sb;

  assign {w0, w1, w2, w3} = rk;
  assign rot   = {w3[23:0], w3[31:24]};
  assign rnext = rcnt + 4'd1;

  aes_sub_bytes u_subword (
    .din  ({96'h0, rot}),
    .dout (sb_out)
  );

  // Only the low word carries SubWord; the zero-fed bytes are discarded.
  assign unused_sb = ^sb_out[127:32];

  assign t  = sb_out[31:0] ^ {rcon(rnext), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    load   = 1'b0;
    xfer   = 1'b0;
    last   = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          st_nxt = RUN;
        end
      end
      RUN: begin
        if (state_in_valid) begin
          xfer = 1'b1;
          if (rcnt == LAST) begin
            last   = 1'b1;
            st_nxt = IDLE;
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk        <= '0;
      rcnt      <= '0;
      state_out <= '0;
      round_idx <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= xfer;
      done      <= last;
      if (load) begin
        rk   <= key;
        rcnt <= '0;
      end
      if (xfer) begin
        state_out <= state_in ^ rk;
        round_idx <= rcnt;
        // Round key 10 is kept after the final round.
        if (!last) begin
          rk   <= {n0, n1, n2, n3};
          rcnt <= rnext;
        end
      end
    end
  end

  assign busy           = (st == RUN);
  assign state_in_ready = (st == RUN);
  assign round_key      = rk;

endmodule
